// File: rtl/sc_display_scan_controller_if.sv
// Signal bundle between the scan controller and whatever drives its digit
// values and consumes its decoder/encoder outputs.
interface sc_display_scan_controller_if #(
  parameter int DATAWIDTH_SELECTION = 3,
  parameter int DATAWIDTH_DIGIT     = 4,
  parameter int NUM_DIGITS          = 4
);

  logic                                  SC_SCAN_Enable_In;
  logic [NUM_DIGITS-1:0]                 SC_SCAN_DigitMask_In;
  logic [NUM_DIGITS*DATAWIDTH_DIGIT-1:0] SC_SCAN_Data_In;
  logic [DATAWIDTH_SELECTION-1:0]        SC_SCAN_Selection_Out;
  logic [DATAWIDTH_DIGIT-1:0]            SC_SCAN_DigitData_Out;
  logic [1:0]                            SC_SCAN_ActiveDigit_Out;
  logic                                  SC_SCAN_FrameStart_Out;

  // Side that supplies enable, mask and digit values and observes the scan.
  modport master (
    output SC_SCAN_Enable_In,
    output SC_SCAN_DigitMask_In,
    output SC_SCAN_Data_In,
    input  SC_SCAN_Selection_Out,
    input  SC_SCAN_DigitData_Out,
    input  SC_SCAN_ActiveDigit_Out,
    input  SC_SCAN_FrameStart_Out
  );

  // The scan controller itself.
  modport slave (
    input  SC_SCAN_Enable_In,
    input  SC_SCAN_DigitMask_In,
    input  SC_SCAN_Data_In,
    output SC_SCAN_Selection_Out,
    output SC_SCAN_DigitData_Out,
    output SC_SCAN_ActiveDigit_Out,
    output SC_SCAN_FrameStart_Out
  );

endinterface

// File: rtl/sc_display_scan_controller.sv
// Time-multiplexed scan scheduler for a common-anode multi-digit display.
// Each digit gets a blanking gap followed by a fixed dwell; digit values
// come from a snapshot taken once per frame so a frame is always coherent.
// Every output is driven from a register so the digit lines never glitch.
module sc_display_scan_controller #(
  parameter int DATAWIDTH_SELECTION = 3,
  parameter int DATAWIDTH_DIGIT     = 4,
  parameter int NUM_DIGITS          = 4,
  parameter int DATAWIDTH_COUNTER   = 16,
  parameter int DWELL_CYCLES        = 50000,
  parameter int BLANK_CYCLES        = 500
) (
  input  logic                                SC_SCAN_CLOCK_50,
  input  logic                                SC_SCAN_RESET_InLow,
  sc_display_scan_controller_if.slave         scan_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scanState_t;

  localparam int SNAP_W = NUM_DIGITS * DATAWIDTH_DIGIT;

  localparam logic [DATAWIDTH_COUNTER-1:0]   BLANK_LAST = DATAWIDTH_COUNTER'(BLANK_CYCLES - 1);
  localparam logic [DATAWIDTH_COUNTER-1:0]   DWELL_LAST = DATAWIDTH_COUNTER'(DWELL_CYCLES - 1);
  localparam logic [1:0]                     LAST_IDX   = 2'(NUM_DIGITS - 1);
  localparam logic [DATAWIDTH_SELECTION-1:0] ALL_OFF    = '1;

  scanState_t                     state_q, state_d;
  logic [DATAWIDTH_COUNTER-1:0]   counter_q, counter_d;
  logic [1:0]                     idx_q, idx_d;
  logic [SNAP_W-1:0]              snapshot_q, snapshot_d;
  logic [DATAWIDTH_SELECTION-1:0] selection_q, selection_d;
  logic [DATAWIDTH_DIGIT-1:0]     digitData_q, digitData_d;
  logic                           frameStart_q, frameStart_d;

  // Register all state and the outputs; reset wins over every other input.
  always_ff @(posedge SC_SCAN_CLOCK_50) begin
    if (!SC_SCAN_RESET_InLow) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      idx_q        <= '0;
      snapshot_q   <= '0;
      selection_q  <= ALL_OFF;
      digitData_q  <= '0;
      frameStart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      idx_q        <= idx_d;
      snapshot_q   <= snapshot_d;
      selection_q  <= selection_d;
      digitData_q  <= digitData_d;
      frameStart_q <= frameStart_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they line up with the state register.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    idx_d        = idx_q;
    snapshot_d   = snapshot_q;
    frameStart_d = 1'b0;
    selection_d  = ALL_OFF;
    digitData_d  = '0;

    case (state_q)
      IDLE: begin
        counter_d = '0;
        idx_d     = '0;
        if (scan_if.SC_SCAN_Enable_In) begin
          state_d      = BLANK;
          snapshot_d   = scan_if.SC_SCAN_Data_In;
          frameStart_d = 1'b1;
        end
      end
      BLANK: begin
        if (!scan_if.SC_SCAN_Enable_In) begin
          state_d   = IDLE;
          counter_d = '0;
          idx_d     = '0;
        end else if (counter_q == BLANK_LAST) begin
          state_d   = SHOW;
          counter_d = '0;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      SHOW: begin
        if (!scan_if.SC_SCAN_Enable_In) begin
          state_d   = IDLE;
          counter_d = '0;
          idx_d     = '0;
        end else if (counter_q == DWELL_LAST) begin
          state_d   = BLANK;
          counter_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d        = '0;
            snapshot_d   = scan_if.SC_SCAN_Data_In;
            frameStart_d = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
        idx_d     = '0;
      end
    endcase

    if ((state_d == SHOW) && scan_if.SC_SCAN_DigitMask_In[idx_d]) begin
      selection_d = {{(DATAWIDTH_SELECTION-2){1'b0}}, idx_d};
    end
    digitData_d = snapshot_d[idx_d*DATAWIDTH_DIGIT +: DATAWIDTH_DIGIT];
  end

  assign scan_if.SC_SCAN_Selection_Out   = selection_q;
  assign scan_if.SC_SCAN_DigitData_Out   = digitData_q;
  assign scan_if.SC_SCAN_ActiveDigit_Out = idx_q;
  assign scan_if.SC_SCAN_FrameStart_Out  = frameStart_q;

endmodule

// File: doc/sc_display_scan_controller.md
Name: sc_display_scan_controller

Overview:
- Time-multiplexed scan scheduler for a 4-digit common-anode display.
- Drives the 3-bit selection input of the active-low digit decoder. That decoder maps 000..011 to one low digit line and 111 to all lines off.
- Steps through the digits with a fixed dwell time and inserts a blanking gap between digits to prevent ghosting.
- Presents each digit's 4-bit value to the downstream 7-segment encoder. A 16-bit value snapshot is taken once per frame, so the displayed frame is always coherent.

Parameters:
- DATAWIDTH_SELECTION, 3, width of the selection output to the decoder.
- DATAWIDTH_DIGIT, 4, bits per digit value.
- NUM_DIGITS, 4, digits scanned per frame (1..4).
- DATAWIDTH_COUNTER, 16, phase counter width. DWELL_CYCLES and BLANK_CYCLES must fit in it.
- DWELL_CYCLES, 50000, clocks each digit is shown (>=1).
- BLANK_CYCLES, 500, clocks all digits are off between digits (>=1).

Ports:
- SC_SCAN_CLOCK_50  in  1  system clock, all logic on rising edge.
- SC_SCAN_RESET_InLow  in  1  synchronous reset, active low.
- SC_SCAN_Enable_In  in  1  1 = scanning active, 0 = display off.
- SC_SCAN_DigitMask_In  in  NUM_DIGITS  bit i = 1 lights digit i.
- SC_SCAN_Data_In  in  NUM_DIGITS*DATAWIDTH_DIGIT  digit values; digit i = bits [4i+3:4i].
- SC_SCAN_Selection_Out  out  DATAWIDTH_SELECTION  to decoder: {0,idx} = show digit idx, 3'b111 = all off.
- SC_SCAN_DigitData_Out  out  DATAWIDTH_DIGIT  value of the current digit from the snapshot.
- SC_SCAN_ActiveDigit_Out  out  2  current digit index.
- SC_SCAN_FrameStart_Out  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- One clock domain. Reset is synchronous and active-low: SC_SCAN_RESET_InLow is sampled on the rising edge of SC_SCAN_CLOCK_50. Reset has priority over every other input.
- Reset values: state=IDLE, idx=0, counter=0, snapshot=0, Selection_Out=3'b111, DigitData_Out=0, ActiveDigit_Out=0, FrameStart_Out=0.
- All outputs are registered. They are never a combinational function of any input (Moore style, glitch-free digit lines).
- States: IDLE, BLANK, SHOW.
- IDLE:
  - Selection_Out=111, counter=0, idx=0.
  - If Enable_In=1 at an edge: go to BLANK, latch Data_In into the snapshot, and assert FrameStart_Out for the next cycle.
- BLANK:
  - Selection_Out=111 for exactly BLANK_CYCLES cycles; the counter runs 0..BLANK_CYCLES-1.
  - At the terminal count: go to SHOW, counter=0.
- SHOW:
  - Lasts exactly DWELL_CYCLES cycles.
  - Selection_Out={0,idx} if DigitMask_In[idx]=1, else 111. The mask is sampled each cycle.
  - A masked digit still consumes its dwell time, so the frame period and brightness stay constant.
  - DigitData_Out=snapshot[4*idx+3:4*idx].
  - At the terminal count: go to BLANK, counter=0, idx=idx+1. If idx was NUM_DIGITS-1, wrap idx to 0, re-latch the snapshot and pulse FrameStart_Out.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles. FrameStart_Out is high only during the first BLANK cycle of each frame.
- Changes to Data_In mid-frame are ignored until the next frame start.
- Enable_In=0 in BLANK or SHOW: the next edge goes to IDLE, Selection_Out=111, idx=0, counter=0. The snapshot is held.
- Re-enable always restarts at digit 0 with a fresh snapshot and a FrameStart pulse.
- Enable_In=1 in the same cycle as reset: reset wins. The frame starts on the first edge after reset is released, if Enable_In is still 1.
- ActiveDigit_Out equals idx in all states. It is 0 in IDLE.
- Selection values 100..110 are never driven.

Test Plan (NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2):
1. Reset: RESET_InLow=0 for 3 cycles with Enable_In=1 -> Selection=111, DigitData=0, FrameStart=0 throughout; state stays IDLE while reset is low.
2. Enable=1, mask=1111, Data=16'hA5C3:
   - FrameStart=1 for 1 cycle.
   - Sequence (2 cycles Selection=111, then 4 cycles of the digit): 000/data 3, 001/data C, 010/data 5, 011/data A.
   - Next FrameStart exactly 24 cycles after the first.
3. Data changed to 16'h1234 at cycle 10 of a frame -> digits 2 and 3 still show 5 and A; the next frame shows 4,3,2,1.
4. Mask=1010 -> digits 0 and 2 hold Selection=111 during SHOW; digits 1 and 3 drive 001 and 011; frame period still 24.
5. Enable dropped during digit 2's SHOW -> next cycle Selection=111, ActiveDigit=0. Re-enable -> FrameStart pulse, then 2 blank cycles, then Selection=000 with the new snapshot.
6. Reset pulsed low for 1 cycle mid-SHOW with Enable held 1 -> IDLE reset values next cycle. The next edge starts a new frame: FrameStart=1, digit 0 after 2 blank cycles.
